// File: rtl/data_bus_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_bus_responder_pkg
// Shared definitions for the data-space responder: FSM state encodings and
// the default window base/depth constants.  The CPU stack start uses the
// same constants, so the two always agree on where data memory sits.
// No ports (package).
// ---------------------------------------------------------------------------
package data_bus_responder_pkg;

    localparam int DBR_DEFAULT_BASE  = 0;
    localparam int DBR_DEFAULT_DEPTH = 64;
    localparam int DBR_WAIT_W        = 4;

    typedef enum logic [1:0] {
        DBR_CLEAR = 2'd0,
        DBR_IDLE  = 2'd1,
        DBR_WAIT  = 2'd2,
        DBR_RESP  = 2'd3
    } dbr_state_e;

endpackage

// File: rtl/dbr_sram.sv
// ---------------------------------------------------------------------------
// dbr_sram
// Single-port synchronous byte array with a registered read.  The read
// register returns zero whenever no read is requested, so the owner can
// drive it straight onto a bus that must idle at zero.
// Ports:
//   clk    in  : clock, rising edge
//   reset  in  : synchronous active-high reset (read register only)
//   we     in  : write enable, mem[addr] <= wdata on the edge
//   re     in  : read enable, rdata <= mem[addr] on the edge, else 0
//   addr   in  : word index
//   wdata  in  : write data
//   rdata  out : registered read data
// ---------------------------------------------------------------------------
module dbr_sram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Array write port; contents are established by the owner's clear sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read that parks at zero when no read is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_bus_responder.sv
// ---------------------------------------------------------------------------
// data_bus_responder
// Byte-wide data-space responder for the CPU data bus.  Accepts one req/ack
// transaction at a time, inserts WAIT_STATES extra cycles, flags addresses
// outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH) with err, and zero-fills the
// array after every reset (busy high during the sweep).
// Ports:
//   clk, reset  in  : clock and synchronous active-high reset
//   req         in  : request, held until ack
//   we          in  : 1 = write, 0 = read
//   addr        in  : byte address
//   wdata       in  : write data
//   ack         out : one-cycle completion pulse
//   rdata       out : read data, valid with ack on in-range reads, else 0
//   err         out : out-of-range indication, with ack
//   busy        out : clear sweep in progress, requests ignored
//   txn_count   out : completed transactions (wrapping)
// ---------------------------------------------------------------------------
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int D_ADDR_WIDTH = 16,
    parameter int MEM_DEPTH    = DBR_DEFAULT_DEPTH,
    parameter int BASE_ADDR    = DBR_DEFAULT_BASE,
    parameter int WAIT_STATES  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [D_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    ack,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic                    busy,
    output logic [15:0]             txn_count
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [D_ADDR_WIDTH-1:0] BASE_W   = D_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [D_ADDR_WIDTH-1:0] DEPTH_W  = D_ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(MEM_DEPTH - 1);
    localparam logic [DBR_WAIT_W-1:0]   WAIT_LOAD = DBR_WAIT_W'(WAIT_STATES - 1);
    localparam logic                    NO_WAIT  = (WAIT_STATES == 0);

    dbr_state_e              state_r;
    logic                    we_r;
    logic [D_ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DBR_WAIT_W-1:0]   wait_cnt_r;
    logic [IDX_W-1:0]        clr_idx_r;
    logic                    ack_r;
    logic                    err_r;
    logic                    busy_r;
    logic [15:0]             txn_count_r;

    logic                    txn_we_s;
    logic [D_ADDR_WIDTH-1:0] txn_addr_s;
    logic [DATA_WIDTH-1:0]   txn_wdata_s;
    logic [D_ADDR_WIDTH-1:0] offset_s;
    logic                    in_range_s;
    logic                    enter_resp_s;
    logic                    mem_we_s;
    logic                    mem_re_s;
    logic [IDX_W-1:0]        mem_addr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic [DATA_WIDTH-1:0]   mem_rdata_s;

    // Transaction view: live bus in IDLE (needed when there are no wait
    // states), latched copy afterwards so later bus changes are ignored.
    always_comb begin
        txn_we_s    = we_r;
        txn_addr_s  = addr_r;
        txn_wdata_s = wdata_r;
        if (state_r == DBR_IDLE) begin
            txn_we_s    = we;
            txn_addr_s  = addr;
            txn_wdata_s = wdata;
        end else begin
            txn_we_s    = we_r;
            txn_addr_s  = addr_r;
            txn_wdata_s = wdata_r;
        end
        // Full-width subtraction: addresses below the base wrap to a large
        // offset and fail the compare, so nothing aliases into the window.
        offset_s   = txn_addr_s - BASE_W;
        in_range_s = (offset_s < DEPTH_W);
    end

    // Marks the edge on which the FSM moves into RESP.
    always_comb begin
        enter_resp_s = 1'b0;
        case (state_r)
            DBR_IDLE: enter_resp_s = req && NO_WAIT;
            DBR_WAIT: enter_resp_s = (wait_cnt_r == {DBR_WAIT_W{1'b0}});
            default:  enter_resp_s = 1'b0;
        endcase
    end

    // SRAM port mux: clear sweep owns the array in CLEAR, otherwise the
    // transaction commits/reads on the edge entering RESP.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_addr_s  = {IDX_W{1'b0}};
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        if (state_r == DBR_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_idx_r;
            mem_wdata_s = {DATA_WIDTH{1'b0}};
        end else begin
            mem_we_s    = enter_resp_s && txn_we_s && in_range_s && !reset;
            mem_re_s    = enter_resp_s && !txn_we_s && in_range_s;
            mem_addr_s  = offset_s[IDX_W-1:0];
            mem_wdata_s = txn_wdata_s;
        end
    end

    dbr_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (IDX_W)
    ) u_sram (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Control FSM with registered ack/err/busy and the transaction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= DBR_CLEAR;
            clr_idx_r   <= {IDX_W{1'b0}};
            busy_r      <= 1'b1;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            txn_count_r <= 16'd0;
            we_r        <= 1'b0;
            addr_r      <= {D_ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            wait_cnt_r  <= {DBR_WAIT_W{1'b0}};
        end else begin
            case (state_r)
                DBR_CLEAR: begin
                    if (clr_idx_r == LAST_IDX) begin
                        state_r <= DBR_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        clr_idx_r <= clr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                DBR_IDLE: begin
                    if (req) begin
                        we_r       <= we;
                        addr_r     <= addr;
                        wdata_r    <= wdata;
                        wait_cnt_r <= WAIT_LOAD;
                        if (enter_resp_s) begin
                            state_r <= DBR_RESP;
                            ack_r   <= 1'b1;
                            err_r   <= !in_range_s;
                        end else begin
                            state_r <= DBR_WAIT;
                        end
                    end
                end
                DBR_WAIT: begin
                    if (enter_resp_s) begin
                        state_r <= DBR_RESP;
                        ack_r   <= 1'b1;
                        err_r   <= !in_range_s;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - {{(DBR_WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
                DBR_RESP: begin
                    state_r     <= DBR_IDLE;
                    ack_r       <= 1'b0;
                    err_r       <= 1'b0;
                    txn_count_r <= txn_count_r + 16'd1;
                end
                default: begin
                    state_r   <= DBR_CLEAR;
                    clr_idx_r <= {IDX_W{1'b0}};
                    busy_r    <= 1'b1;
                    ack_r     <= 1'b0;
                    err_r     <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = ack_r;
    assign err       = err_r;
    assign busy      = busy_r;
    assign rdata     = mem_rdata_s;
    assign txn_count = txn_count_r;

endmodule

// File: tb/tb_data_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_data_bus_responder
// Two responder instances: "a" with the default window (base 0, one wait
// state) and "b" with base 0x60 and no wait states.  A byte-array model per
// instance predicts every read, error flag, latency and transaction count.
// ---------------------------------------------------------------------------
module tb_data_bus_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_a = 1'b0, we_a = 1'b0;
    logic [15:0] addr_a = 16'h0000;
    logic [7:0]  wdata_a = 8'h00;
    logic        ack_a, err_a, busy_a;
    logic [7:0]  rdata_a;
    logic [15:0] cnt_a;

    logic        req_b = 1'b0, we_b = 1'b0;
    logic [15:0] addr_b = 16'h0000;
    logic [7:0]  wdata_b = 8'h00;
    logic        ack_b, err_b, busy_b;
    logic [7:0]  rdata_b;
    logic [15:0] cnt_b;

    int          sel = 0;
    logic        ack_s, err_s, busy_s;
    logic [7:0]  rdata_s;
    logic [15:0] cnt_s;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem_m [2][64];
    int          cnt_m [2];

    assign ack_s   = (sel == 1) ? ack_b   : ack_a;
    assign err_s   = (sel == 1) ? err_b   : err_a;
    assign busy_s  = (sel == 1) ? busy_b  : busy_a;
    assign rdata_s = (sel == 1) ? rdata_b : rdata_a;
    assign cnt_s   = (sel == 1) ? cnt_b   : cnt_a;

    data_bus_responder dut_a (
        .clk (clk), .reset (reset), .req (req_a), .we (we_a), .addr (addr_a),
        .wdata (wdata_a), .ack (ack_a), .rdata (rdata_a), .err (err_a),
        .busy (busy_a), .txn_count (cnt_a)
    );

    data_bus_responder #(.BASE_ADDR (96), .WAIT_STATES (0)) dut_b (
        .clk (clk), .reset (reset), .req (req_b), .we (we_b), .addr (addr_b),
        .wdata (wdata_b), .ack (ack_b), .rdata (rdata_b), .err (err_b),
        .busy (busy_b), .txn_count (cnt_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        if (sel == 1) begin
            req_b = r; we_b = w; addr_b = a; wdata_b = d;
        end else begin
            req_a = r; we_a = w; addr_a = a; wdata_a = d;
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            cnt_m[k] = 0;
            for (int i = 0; i < 64; i++) mem_m[k][i] = 8'h00;
        end
    endtask

    // Counts busy cycles from the current sample point; returns in IDLE.
    task automatic count_busy(output int n, output logic saw_ack);
        n = 0;
        saw_ack = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_s) break;
            n++;
            if (ack_s) saw_ack = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // One bus transaction; scrambles the bus after acceptance to prove the
    // responder works from its latched copy.
    task automatic txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic e, output int lat);
        lat = 0;
        drive(1'b1, w, a, d);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack_s) break;
            drive(1'b1, ~w, 16'($urandom), 8'($urandom));
        end
        rd = rdata_s;
        e  = err_s;
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(ack_s), 32'd0);
        check("rdata_idle_zero", 32'(rdata_s), 32'd0);
        check("err_idle_zero", 32'(err_s), 32'd0);
    endtask

    task automatic mtxn(input logic w, input logic [15:0] a, input logic [7:0] d, input string tag);
        logic [7:0] rd;
        logic       e;
        int         lat;
        int         base;
        int         ws;
        int         idx;
        bit         inr;
        logic [7:0] exp_rd;
        base = (sel == 1) ? 96 : 0;
        ws   = (sel == 1) ? 0 : 1;
        inr  = (int'(a) >= base) && (int'(a) < base + 64);
        idx  = int'(a) - base;
        exp_rd = 8'h00;
        if (inr && !w) exp_rd = mem_m[sel][idx];
        txn(w, a, d, rd, e, lat);
        check({tag, "_latency"}, 32'(lat), 32'(1 + ws));
        check({tag, "_err"}, 32'(e), 32'(!inr));
        check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        if (inr && w) mem_m[sel][idx] = d;
        cnt_m[sel] = (cnt_m[sel] + 1) % 65536;
        check({tag, "_txn_count"}, 32'(cnt_s), 32'(cnt_m[sel]));
    endtask

    initial begin
        int         n;
        logic       saw;
        logic [15:0] a;
        logic [15:0] last_a;
        logic        w;

        clear_model();
        last_a = 16'h0000;

        // Power-up reset and clear sweep.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sel = 0;
        check("reset_ack", 32'(ack_s), 32'd0);
        check("reset_err", 32'(err_s), 32'd0);
        check("reset_rdata", 32'(rdata_s), 32'd0);
        check("reset_txn_count", 32'(cnt_s), 32'd0);
        check("reset_busy", 32'(busy_s), 32'd1);
        count_busy(n, saw);
        check("clear_busy_cycles", 32'(n), 32'd64);

        // Every location reads back zero after the sweep.
        for (int i = 0; i < 64; i++) mtxn(1'b0, 16'(i), 8'h00, "clear_read");

        // Write then read back.
        mtxn(1'b1, 16'h0010, 8'h5A, "wr_5a");
        mtxn(1'b0, 16'h0010, 8'h00, "rd_5a");

        // Stack pattern: push two bytes at the top, pop in LIFO order.
        mtxn(1'b1, 16'h003F, 8'h05, "push_05");
        mtxn(1'b1, 16'h003E, 8'h0F, "push_0f");
        mtxn(1'b0, 16'h003E, 8'h00, "pop_0f");
        mtxn(1'b0, 16'h003F, 8'h00, "pop_05");

        // Random traffic on the default window, including out-of-range and
        // read-right-after-write of the same address.
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 9);
            if (n < 7)      a = 16'($urandom_range(0, 63));
            else if (n < 9) a = 16'($urandom_range(64, 255));
            else            a = 16'($urandom);
            w = 1'($urandom_range(0, 1));
            if ((i % 3) == 2) begin
                a = last_a;
                w = 1'b0;
            end
            last_a = a;
            mtxn(w, a, 8'($urandom), "rand_a");
        end

        // Offset window, no wait states.
        sel = 1;
        mtxn(1'b1, 16'h005F, 8'hAA, "oor_below_wr");
        mtxn(1'b0, 16'h00A0, 8'h00, "oor_above_rd");
        mtxn(1'b0, 16'h0060, 8'h00, "base_rd_no_alias");
        mtxn(1'b0, 16'h009F, 8'h00, "top_rd_no_alias");
        mtxn(1'b1, 16'h0061, 8'hC3, "wr_c3");
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom_range(16'h0050, 16'h00AF));
            mtxn(1'($urandom_range(0, 1)), a, 8'($urandom), "rand_b");
        end

        // Back-to-back reads with req held: ack every second cycle.
        drive(1'b1, 1'b0, 16'h0061, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("b2b_ack", 32'(ack_s), 32'((i % 2) == 0));
            if ((i % 2) == 0) check("b2b_rdata", 32'(rdata_s), 32'(mem_m[1][1]));
        end
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        @(posedge clk); #1;
        check("b2b_ack_end", 32'(ack_s), 32'd0);
        cnt_m[1] = cnt_m[1] + 3;
        check("b2b_txn_count", 32'(cnt_s), 32'(cnt_m[1]));

        // Reset during WAIT of a write: no ack, no commit, sweep restarts.
        sel = 0;
        mtxn(1'b1, 16'h0005, 8'h11, "pre_reset_wr");
        drive(1'b1, 1'b1, 16'h0005, 8'h77);
        @(posedge clk); #1;
        check("midreset_no_early_ack", 32'(ack_s), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        check("midreset_ack", 32'(ack_s), 32'd0);
        check("midreset_busy", 32'(busy_s), 32'd1);
        clear_model();
        count_busy(n, saw);
        check("midreset_busy_cycles", 32'(n), 32'd64);
        check("midreset_no_ack_in_sweep", 32'(saw), 32'd0);
        check("midreset_txn_count", 32'(cnt_s), 32'd0);
        mtxn(1'b0, 16'h0005, 8'h00, "midreset_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
